mrsc_stream_encoder: RTL and testbench

Parametrised, pipelined successor to the combinational MRSC encoder. It accepts a ROWS×COLS data word over a valid/ready stream and emits the codeword {vertical checks, horizontal checks, data} over a second valid/ready stream. It adds full backpressure, a fixed two-cycle latency at one word per cycle, and a running count of encoded words. It sits between the memory write-data path and the protected storage array.

---
 rtl/mrsc_stream_encoder.sv | 122 ++++++++++++
 tb/tb_mrsc_stream_encoder.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mrsc_stream_encoder.sv
// Pipelined MRSC encoder: ROWSxCOLS data word in, {vertical, horizontal, data} codeword out.
// Two-stage valid/ready pipeline with full backpressure and a running output-transfer count.
module mrsc_stream_encoder #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int CNT_W = 16,
    localparam int DATA_W = ROWS * COLS,
    localparam int H_W    = 2 * ROWS,
    localparam int V_W    = 2 * COLS,
    localparam int CW_W   = DATA_W + H_W + V_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_word,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [CW_W-1:0]   encoded_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  word_count
);

    if ((ROWS % 2) != 0 || ROWS < 2) begin : g_bad_rows
        $fatal(1, "mrsc_stream_encoder: ROWS must be even and >= 2");
    end
    if ((COLS % 2) != 0 || COLS < 2) begin : g_bad_cols
        $fatal(1, "mrsc_stream_encoder: COLS must be even and >= 2");
    end

    // Row checks: one parity bit per row per column half.
    function automatic logic [H_W-1:0] row_checks(input logic [DATA_W-1:0] d);
        logic [H_W-1:0] h;
        h = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (c < COLS / 2) h[2*r]   = h[2*r]   ^ d[r*COLS + c];
                else              h[2*r+1] = h[2*r+1] ^ d[r*COLS + c];
            end
        end
        return h;
    endfunction

    // Column checks: one parity bit per column per row half.
    function automatic logic [V_W-1:0] col_checks(input logic [DATA_W-1:0] d);
        logic [V_W-1:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (r < ROWS / 2) v[c]        = v[c]        ^ d[r*COLS + c];
                else              v[COLS + c] = v[COLS + c] ^ d[r*COLS + c];
            end
        end
        return v;
    endfunction

    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_data_q,  s1_data_d;
    logic              out_valid_q, out_valid_d;
    logic [CW_W-1:0]   encoded_q,  encoded_d;
    logic [CNT_W-1:0]  word_count_q, word_count_d;

    logic s2_ready;
    logic in_fire;
    logic s1_adv;
    logic out_fire;

    // in_ready is combinational from out_ready so a full pipeline keeps streaming without bubbles.
    assign s2_ready = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_ready;
    assign in_fire  = in_valid && in_ready;
    assign s1_adv   = s1_valid_q && s2_ready;
    assign out_fire = out_valid_q && out_ready;

    // NOTE: every variable gets a hold default first so no path through the block leaves it unassigned (no latch).
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_data_d    = s1_data_q;
        out_valid_d  = out_valid_q;
        encoded_d    = encoded_q;
        word_count_d = word_count_q;

        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_data_d  = in_word;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s1_adv) begin
            out_valid_d = 1'b1;
            encoded_d   = {col_checks(s1_data_q), row_checks(s1_data_q), s1_data_q};
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end

        if (out_fire) begin
            word_count_d = word_count_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            out_valid_q  <= 1'b0;
            encoded_q    <= '0;
            word_count_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_data_q    <= s1_data_d;
            out_valid_q  <= out_valid_d;
            encoded_q    <= encoded_d;
            word_count_q <= word_count_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign encoded_word = encoded_q;
    assign word_count   = word_count_q;

endmodule

// File: tb/tb_mrsc_stream_encoder.sv
// Self-checking bench for mrsc_stream_encoder: default 4x4 instance plus a 2x4 instance
// with a 4-bit counter, checked against a bit-by-bit parity model of the codeword.
module tb_mrsc_stream_encoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default instance
    logic [15:0] in_word   = '0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [31:0] encoded_word;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] word_count;

    // ROWS=2, COLS=4, CNT_W=4 instance
    logic [7:0]  s_in_word   = '0;
    logic        s_in_valid  = 1'b0;
    logic        s_in_ready;
    logic [19:0] s_encoded_word;
    logic        s_out_valid;
    logic        s_out_ready = 1'b0;
    logic [3:0]  s_word_count;

    mrsc_stream_encoder dut (
        .clk(clk), .rst(rst),
        .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
        .encoded_word(encoded_word), .out_valid(out_valid), .out_ready(out_ready),
        .word_count(word_count)
    );

    mrsc_stream_encoder #(.ROWS(2), .COLS(4), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst),
        .in_word(s_in_word), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .encoded_word(s_encoded_word), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .word_count(s_word_count)
    );

    int checks = 0;
    int errors = 0;

    // Each data bit toggles its row-half parity bit and its column-half parity bit.
    function automatic logic [63:0] ref_encode(input logic [63:0] w, input int rows, input int cols);
        logic [63:0] h, v, data;
        int dw;
        dw = rows * cols;
        h = '0;
        v = '0;
        data = w & ((64'd1 << dw) - 64'd1);
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                if (data[r*cols + c]) begin
                    h[2*r + c / (cols/2)]       = ~h[2*r + c / (cols/2)];
                    v[(r / (rows/2))*cols + c] = ~v[(r / (rows/2))*cols + c];
                end
            end
        end
        return (v << (dw + 2*rows)) | (h << dw) | data;
    endfunction

    function automatic logic [31:0] ref32(input logic [15:0] w);
        logic [63:0] full;
        full = ref_encode({48'd0, w}, 4, 4);
        return full[31:0];
    endfunction

    function automatic logic [19:0] ref20(input logic [7:0] w);
        logic [63:0] full;
        full = ref_encode({56'd0, w}, 2, 4);
        return full[19:0];
    endfunction

    task automatic expect1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b exp %b", name, got, exp);
        end
    endtask

    task automatic expect32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        #1;
        expect1("rst_out_valid", out_valid, 1'b0);
        expect32("rst_encoded", encoded_word, 32'h0);
        expect32("rst_count", {16'd0, word_count}, 32'd0);
        rst = 1'b0;
        #1;
        expect1("rst_in_ready", in_ready, 1'b1);
    endtask

    // Sends one word with out_ready high and checks the two-edge latency and codeword.
    task automatic send_one(input string name, input logic [15:0] w, input logic [31:0] exp);
        @(negedge clk);
        in_word   = w;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        expect1({name, "_in_ready"}, in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        expect1({name, "_not_yet"}, out_valid, 1'b0);
        @(negedge clk);
        #1;
        expect1({name, "_out_valid"}, out_valid, 1'b1);
        expect32(name, encoded_word, exp);
        expect32({name, "_model"}, encoded_word, ref32(w));
        @(negedge clk);
        #1;
        expect1({name, "_drained"}, out_valid, 1'b0);
    endtask

    task automatic test_single;
        send_one("single_80fa", 16'h80FA, 32'h858380FA);
    endtask

    task automatic test_corners;
        send_one("corner_ffff", 16'hFFFF, 32'h0000FFFF);
        send_one("corner_0001", 16'h0001, 32'h01010001);
        send_one("corner_0000", 16'h0000, 32'h00000000);
        expect32("corner_count", {16'd0, word_count}, 32'd4);
    endtask

    task automatic test_backpressure;
        logic [15:0] words [3];
        logic [31:0] outs  [$];
        int idx;
        int cyc;
        words[0] = 16'h0001;
        words[1] = 16'hFFFF;
        words[2] = 16'h80FA;
        idx = 0;
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_word  = words[idx];
            in_valid = 1'b1;
            #1;
            if (in_valid && in_ready) idx++;
            @(negedge clk);
        end
        #1;
        expect32("bp_accepted", idx, 2);
        expect1("bp_in_ready", in_ready, 1'b0);
        expect1("bp_out_valid", out_valid, 1'b1);
        expect32("bp_held", encoded_word, 32'h01010001);
        @(negedge clk);
        out_ready = 1'b1;
        cyc = 0;
        while (outs.size() < 3 && cyc < 20) begin
            in_valid = (idx < 3);
            in_word  = words[(idx < 3) ? idx : 2];
            #1;
            if (out_valid && out_ready) outs.push_back(encoded_word);
            if (in_valid && in_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        #1;
        expect32("bp_out_count", outs.size(), 3);
        if (outs.size() == 3) begin
            expect32("bp_out0", outs[0], 32'h01010001);
            expect32("bp_out1", outs[1], 32'h0000FFFF);
            expect32("bp_out2", outs[2], 32'h858380FA);
        end
        expect1("bp_no_extra", out_valid, 1'b0);
        expect32("bp_count", {16'd0, word_count}, 32'd7);
    endtask

    task automatic test_reset_midstream;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_word   = 16'h1234;
        @(negedge clk);
        in_word = 16'h5678;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        expect1("mid_full", in_ready, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        expect1("mid_out_valid", out_valid, 1'b0);
        expect32("mid_encoded", encoded_word, 32'h0);
        expect32("mid_count", {16'd0, word_count}, 32'd0);
        expect1("mid_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            expect1("mid_no_stale", out_valid, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic test_random_stream;
        logic [31:0] q [$];
        logic [31:0] exp;
        int sent;
        int got;
        int cyc;
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < 100 && cyc < 5000) begin
            in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
            in_word   = 16'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            #1;
            expect1("rand_in_ready", in_ready, (q.size() < 2) || out_ready);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_spurious got %h exp none", encoded_word);
                end else begin
                    exp = q.pop_front();
                    expect32("rand_word", encoded_word, exp);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(ref32(in_word));
                sent++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        #1;
        expect32("rand_outputs", got, 100);
        expect32("rand_count", {16'd0, word_count}, 32'd100);
    endtask

    task automatic test_params;
        logic [19:0] q [$];
        logic [19:0] exp;
        int sent;
        int got;
        int cyc;
        sent = 0;
        got  = 0;
        cyc  = 0;
        s_out_ready = 1'b1;
        while (got < 17 && cyc < 200) begin
            s_in_valid = (sent < 17);
            s_in_word  = (sent == 0) ? 8'h01 : 8'($urandom);
            #1;
            if (s_out_valid && s_out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL small_spurious got %h exp none", s_encoded_word);
                end else begin
                    exp = q.pop_front();
                    if (got == 0) expect32("small_01", {12'd0, s_encoded_word}, 32'h01101);
                    expect32("small_word", {12'd0, s_encoded_word}, {12'd0, exp});
                end
                got++;
            end
            if (s_in_valid && s_in_ready) begin
                q.push_back(ref20(s_in_word));
                sent++;
            end
            @(negedge clk);
            cyc++;
        end
        s_in_valid = 1'b0;
        #1;
        expect32("small_outputs", got, 17);
        expect32("small_count_wrap", {28'd0, s_word_count}, 32'd1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_corners();
        test_backpressure();
        test_reset_midstream();
        test_random_stream();
        test_params();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
